fu_complete_arbiter: RTL and testbench

Parametrised completion buffer and arbiter between the functional units and the common data bus (CDB). Each of NUM_FU units pushes finished results into its own FIFO; up to CDB_W results per cycle are granted onto the CDB by fixed-priority or round-robin arbitration. Per-unit backpressure replaces the single-slot buffering and global dispatch stall of the current completion stage, and a flush input supports misprediction recovery.

---
 rtl/fu_complete_arbiter.sv | 111 +++++++++++
 tb/tb_fu_complete_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_complete_arbiter.sv
// fu_complete_arbiter: per-unit completion FIFOs drained onto the CDB by fixed-priority or round-robin grants
module fu_complete_arbiter #(
    parameter int NUM_FU  = 6,
    parameter int DEPTH   = 2,
    parameter int CDB_W   = 1,
    parameter int DATA_W  = 64,
    parameter int RR_MODE = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_FU-1:0]                  fu_valid,
    input  logic [NUM_FU*DATA_W-1:0]           fu_data,
    output logic [NUM_FU-1:0]                  fu_ready,
    input  logic                               cdb_stall,
    input  logic                               flush,
    output logic [CDB_W-1:0]                   cdb_valid,
    output logic [CDB_W*DATA_W-1:0]            cdb_data,
    output logic [CDB_W*$clog2(NUM_FU)-1:0]    cdb_src,
    output logic                               busy
);
    localparam int SW = $clog2(NUM_FU);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]                mem [NUM_FU][DEPTH];
    logic [NUM_FU-1:0][CW-1:0]        count;
    logic [NUM_FU-1:0][PW-1:0]        head;
    logic [NUM_FU-1:0][PW-1:0]        tail;
    logic [SW-1:0]                    rr_ptr;
    logic [SW-1:0]                    rr_nxt;
    logic [NUM_FU-1:0]                cand;
    logic [NUM_FU-1:0]                push;
    logic [NUM_FU-1:0]                pop;
    logic [CDB_W-1:0][SW-1:0]         g_src;
    logic [CDB_W-1:0][DATA_W-1:0]     g_data;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return DEPTH == 1 ? '0 : p + 1'b1;
    endfunction

    // Occupancy flags; ready looks only at the registered count so a full FIFO never accepts
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            cand[i]     = count[i] != '0;
            fu_ready[i] = count[i] != CW'(DEPTH);
        end
        push = fu_valid & fu_ready & {NUM_FU{~flush}};
        busy = |cand;
    end

    // Grant up to CDB_W distinct channels in priority or rotating order; last grant advances rr
    always_comb begin
        logic [SW-1:0] idx;
        idx       = '0;
        cdb_valid = '0;
        g_src     = '0;
        pop       = '0;
        rr_nxt    = rr_ptr;
        for (int k = 0; k < CDB_W; k++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                idx = RR_MODE != 0 ? SW'((int'(rr_ptr) + j) % NUM_FU) : SW'(NUM_FU - 1 - j);
                if (!cdb_stall && !cdb_valid[k] && cand[idx] && !pop[idx]) begin
                    cdb_valid[k] = 1'b1;
                    g_src[k]     = idx;
                    pop[idx]     = 1'b1;
                    rr_nxt       = SW'((int'(idx) + 1) % NUM_FU);
                end
            end
        end
    end

    // Head entries of granted channels drive the bus; idle slots are zero
    always_comb begin
        for (int k = 0; k < CDB_W; k++)
            g_data[k] = cdb_valid[k] ? mem[g_src[k]][head[g_src[k]]] : '0;
    end

    assign cdb_data = g_data;
    assign cdb_src  = g_src;

    // FIFO pointers, counts and round-robin pointer; flush empties everything at the edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            head   <= '0;
            tail   <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            head   <= '0;
            tail   <= '0;
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_nxt;
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i])
                    tail[i] <= inc(tail[i]);
                if (pop[i])
                    head[i] <= inc(head[i]);
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    // Payload storage, written at the tail on every accepted push
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++)
            if (push[i])
                mem[i][tail[i]] <= fu_data[i*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_fu_complete_arbiter.sv
// tb_fu_complete_arbiter: three configurations (rr single, fixed single, rr dual) against a queue-based reference
module tb_fu_complete_arbiter;
    localparam int N  = 6;
    localparam int D  = 2;
    localparam int DW = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    fu_valid = '0;
    logic [N*DW-1:0] fu_data = '0;
    logic            cdb_stall = 1'b0;
    logic            flush = 1'b0;

    logic [N-1:0]    rr_rdy, fp_rdy, du_rdy;
    logic            rr_cv, fp_cv;
    logic [1:0]      du_cv;
    logic [DW-1:0]   rr_cd, fp_cd;
    logic [2*DW-1:0] du_cd;
    logic [2:0]      rr_cs, fp_cs;
    logic [5:0]      du_cs;
    logic            rr_busy, fp_busy, du_busy;

    always #5 clock = ~clock;

    fu_complete_arbiter #(.NUM_FU(N), .DEPTH(D), .CDB_W(1), .DATA_W(DW), .RR_MODE(1)) u_rr (
        .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_data(fu_data), .fu_ready(rr_rdy),
        .cdb_stall(cdb_stall), .flush(flush), .cdb_valid(rr_cv), .cdb_data(rr_cd), .cdb_src(rr_cs), .busy(rr_busy));
    fu_complete_arbiter #(.NUM_FU(N), .DEPTH(D), .CDB_W(1), .DATA_W(DW), .RR_MODE(0)) u_fp (
        .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_data(fu_data), .fu_ready(fp_rdy),
        .cdb_stall(cdb_stall), .flush(flush), .cdb_valid(fp_cv), .cdb_data(fp_cd), .cdb_src(fp_cs), .busy(fp_busy));
    fu_complete_arbiter #(.NUM_FU(N), .DEPTH(D), .CDB_W(2), .DATA_W(DW), .RR_MODE(1)) u_du (
        .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_data(fu_data), .fu_ready(du_rdy),
        .cdb_stall(cdb_stall), .flush(flush), .cdb_valid(du_cv), .cdb_data(du_cd), .cdb_src(du_cs), .busy(du_busy));

    // Reference model: one queue per (instance, channel), plus rotating pointer per instance
    logic [DW-1:0]   q [3*N][$];
    int              rr [3];
    int              cw [3];
    int              rrm [3];
    string           nm [3];
    logic [1:0]      ev [3];
    logic [5:0]      es [3];
    logic [2*DW-1:0] ed [3];
    int              n_chk = 0;
    int              n_fail = 0;

    typedef struct packed {
        logic [N-1:0]  v;
        logic [DW-1:0] d;
        logic          s;
        logic          f;
        logic          ev;
        logic [2:0]    es;
        logic [DW-1:0] ed;
        logic [N-1:0]  er;
        logic          eb;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3*N; i++) q[i].delete();
        for (int m = 0; m < 3; m++) rr[m] = 0;
    endtask

    task automatic model_eval();
        for (int m = 0; m < 3; m++) begin
            int n;
            int c;
            n = 0;
            ev[m] = '0;
            es[m] = '0;
            ed[m] = '0;
            for (int j = 0; j < N; j++) begin
                c = rrm[m] != 0 ? (rr[m] + j) % N : N - 1 - j;
                if (!cdb_stall && n < cw[m] && q[m*N+c].size() > 0) begin
                    ev[m] |= 2'(1 << n);
                    es[m] |= 6'(c << (3*n));
                    ed[m] |= 32'(q[m*N+c][0]) << (DW*n);
                    n++;
                end
            end
        end
    endtask

    task automatic model_update();
        logic [N-1:0] rdy;
        int c;
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < N; i++) rdy[i] = q[m*N+i].size() != D;
            if (flush) begin
                for (int i = 0; i < N; i++) q[m*N+i].delete();
                rr[m] = 0;
            end else begin
                for (int k = 0; k < 2; k++)
                    if (ev[m][k]) begin
                        c = int'(es[m][3*k +: 3]);
                        void'(q[m*N+c].pop_front());
                        rr[m] = (c + 1) % N;
                    end
                for (int i = 0; i < N; i++)
                    if (fu_valid[i] && rdy[i]) q[m*N+i].push_back(fu_data[i*DW +: DW]);
            end
        end
    endtask

    task automatic check_all();
        logic [1:0]      a_cv;
        logic [5:0]      a_cs;
        logic [2*DW-1:0] a_cd;
        logic [N-1:0]    a_rdy, e_rdy;
        logic            a_busy, e_busy;
        model_eval();
        for (int m = 0; m < 3; m++) begin
            a_cv   = m == 0 ? {1'b0, rr_cv} : m == 1 ? {1'b0, fp_cv} : du_cv;
            a_cs   = m == 0 ? {3'b0, rr_cs} : m == 1 ? {3'b0, fp_cs} : du_cs;
            a_cd   = m == 0 ? {16'b0, rr_cd} : m == 1 ? {16'b0, fp_cd} : du_cd;
            a_rdy  = m == 0 ? rr_rdy : m == 1 ? fp_rdy : du_rdy;
            a_busy = m == 0 ? rr_busy : m == 1 ? fp_busy : du_busy;
            e_busy = 1'b0;
            for (int i = 0; i < N; i++) begin
                e_rdy[i] = q[m*N+i].size() != D;
                e_busy  |= q[m*N+i].size() != 0;
            end
            chk($sformatf("%s.cdb_valid", nm[m]), 64'(a_cv), 64'(ev[m]));
            chk($sformatf("%s.cdb_src", nm[m]), 64'(a_cs), 64'(es[m]));
            chk($sformatf("%s.cdb_data", nm[m]), 64'(a_cd), 64'(ed[m]));
            chk($sformatf("%s.fu_ready", nm[m]), 64'(a_rdy), 64'(e_rdy));
            chk($sformatf("%s.busy", nm[m]), 64'(a_busy), 64'(e_busy));
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 1ns later
    task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic s, input logic f);
        fu_valid  = v;
        fu_data   = d;
        cdb_stall = s;
        flush     = f;
        #1;
        check_all();
    endtask

    task automatic tick();
        model_update();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive('0, '0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        cw  = '{1, 1, 2};
        rrm = '{1, 0, 1};
        nm  = '{"rr", "fp", "dual"};
        //            v      d       s  f  ev es  ed      er     eb
        tbl[0] = '{6'h00, 16'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h00, 6'h3f, 1'b0};
        tbl[1] = '{6'h04, 16'h55, 1'b0, 1'b0, 1'b0, 3'd0, 16'h00, 6'h3f, 1'b0};
        tbl[2] = '{6'h00, 16'h00, 1'b0, 1'b0, 1'b1, 3'd2, 16'h55, 6'h3f, 1'b1};
        tbl[3] = '{6'h00, 16'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h00, 6'h3f, 1'b0};
        tbl[4] = '{6'h01, 16'h01, 1'b1, 1'b0, 1'b0, 3'd0, 16'h00, 6'h3f, 1'b0};
        tbl[5] = '{6'h01, 16'h02, 1'b1, 1'b0, 1'b0, 3'd0, 16'h00, 6'h3f, 1'b1};
        tbl[6] = '{6'h01, 16'h03, 1'b1, 1'b0, 1'b0, 3'd0, 16'h00, 6'h3e, 1'b1};
        tbl[7] = '{6'h00, 16'h00, 1'b0, 1'b0, 1'b1, 3'd0, 16'h01, 6'h3e, 1'b1};
        tbl[8] = '{6'h00, 16'h00, 1'b0, 1'b0, 1'b1, 3'd0, 16'h02, 6'h3f, 1'b1};
        tbl[9] = '{6'h00, 16'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h00, 6'h3f, 1'b0};
        model_reset();

        // Reset held, then released away from the rising edge
        @(negedge clock);
        #1;
        check_all();
        reset = 1'b0;
        @(negedge clock);

        // Directed vectors: idle, single push, backpressure with stall
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, {N{tbl[i].d}}, tbl[i].s, tbl[i].f);
            chk($sformatf("tbl%0d.valid", i), 64'(rr_cv), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d.src", i), 64'(rr_cs), 64'(tbl[i].es));
            chk($sformatf("tbl%0d.data", i), 64'(rr_cd), 64'(tbl[i].ed));
            chk($sformatf("tbl%0d.ready", i), 64'(rr_rdy), 64'(tbl[i].er));
            chk($sformatf("tbl%0d.busy", i), 64'(rr_busy), 64'(tbl[i].eb));
            tick();
        end

        // Fixed priority: ch1, ch4, ch5 together drain as 5, 4, 1
        drive(6'b110010, {N{16'h0007}}, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive('0, '0, 1'b0, 1'b0);
            chk($sformatf("fp_order%0d.valid", i), 64'(fp_cv), 64'(1));
            chk($sformatf("fp_order%0d.src", i), 64'(fp_cs), 64'(i == 0 ? 5 : i == 1 ? 4 : 1));
            tick();
        end
        idle(2);

        // Round-robin fairness: ch0 and ch3 always loaded, grants alternate
        drive(6'b001001, {N{16'h0011}}, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(6'b001001, {N{16'(16'h0020 + i)}}, 1'b0, 1'b0);
            chk($sformatf("rr_fair%0d.valid", i), 64'(rr_cv), 64'(1));
            chk($sformatf("rr_fair%0d.src", i), 64'(rr_cs), 64'(i % 2 == 0 ? 0 : 3));
            tick();
        end
        idle(6);

        // Flush: two entries on ch3, then flush with a ch0 push in the same cycle
        drive(6'b001000, {N{16'h0031}}, 1'b1, 1'b0);
        tick();
        drive(6'b001000, {N{16'h0032}}, 1'b1, 1'b0);
        tick();
        drive(6'b000001, {N{16'h00ab}}, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive('0, '0, 1'b0, 1'b0);
            chk($sformatf("flush%0d.valid", i), 64'(rr_cv), 64'(0));
            chk($sformatf("flush%0d.busy", i), 64'(rr_busy), 64'(0));
            chk($sformatf("flush%0d.ready", i), 64'(rr_rdy), 64'(6'h3f));
            tick();
        end

        // Asynchronous reset mid-operation empties the FIFOs without a clock edge
        drive(6'b001000, {N{16'h0041}}, 1'b1, 1'b0);
        tick();
        drive(6'b001000, {N{16'h0042}}, 1'b1, 1'b0);
        tick();
        fu_valid = '0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("areset.busy", 64'(rr_busy), 64'(0));
        chk("areset.ready", 64'(du_rdy), 64'(6'h3f));
        @(negedge clock);
        reset = 1'b0;
        cdb_stall = 1'b0;

        // Dual issue: steer rr_ptr to 4 via a ch3 grant, then load ch1, ch2, ch5
        drive(6'b001000, {N{16'h0050}}, 1'b0, 1'b0);
        tick();
        idle(1);
        drive(6'b100110, {N{16'h0060}}, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        chk("dual0.valid", 64'(du_cv), 64'(2'b11));
        chk("dual0.src", 64'(du_cs), 64'({3'd1, 3'd5}));
        tick();
        drive('0, '0, 1'b0, 1'b0);
        chk("dual1.valid", 64'(du_cv), 64'(2'b01));
        chk("dual1.src", 64'(du_cs), 64'({3'd0, 3'd2}));
        tick();
        drive(6'b011001, {N{16'h0070}}, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        chk("dual2.valid", 64'(du_cv), 64'(2'b11));
        chk("dual2.src", 64'(du_cs), 64'({3'd4, 3'd3}));
        tick();
        idle(4);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(N'($urandom), {$urandom, $urandom, $urandom},
                  $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
            tick();
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
